// File: rtl/rv_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_enc_pkg
// Brief    : Operation codes, RV32I field constants and the field-to-word
//            encode function shared by the instruction encoder.
// Revision : 1.0 - initial release
// ============================================================================
package rv_enc_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_SLL   = 5'd2,
        OP_SLT   = 5'd3,
        OP_SLTU  = 5'd4,
        OP_XOR   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_OR    = 5'd8,
        OP_AND   = 5'd9,
        OP_ADDI  = 5'd10,
        OP_SLTI  = 5'd11,
        OP_SLTIU = 5'd12,
        OP_XORI  = 5'd13,
        OP_ORI   = 5'd14,
        OP_ANDI  = 5'd15,
        OP_SLLI  = 5'd16,
        OP_SRLI  = 5'd17,
        OP_SRAI  = 5'd18
    } op_e;

    localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
    localparam logic [6:0]  OPC_ITYPE = 7'b0010011;

    localparam logic [2:0]  F3_ADD  = 3'b000;
    localparam logic [2:0]  F3_SLL  = 3'b001;
    localparam logic [2:0]  F3_SLT  = 3'b010;
    localparam logic [2:0]  F3_SLTU = 3'b011;
    localparam logic [2:0]  F3_XOR  = 3'b100;
    localparam logic [2:0]  F3_SR   = 3'b101;
    localparam logic [2:0]  F3_OR   = 3'b110;
    localparam logic [2:0]  F3_AND  = 3'b111;

    localparam logic [6:0]  F7_BASE = 7'b0000000;
    localparam logic [6:0]  F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    function automatic logic op_is_legal(input logic [4:0] op);
        return op <= OP_SRAI;
    endfunction

    function automatic logic op_is_alu_imm(input logic [4:0] op);
        return (op >= OP_ADDI) && (op <= OP_ANDI);
    endfunction

    function automatic logic op_is_shift_imm(input logic [4:0] op);
        return (op >= OP_SLLI) && (op <= OP_SRAI);
    endfunction

    // Unknown operations fall through to NOP so the consumer never sees garbage.
    function automatic logic [31:0] encode_word(
        input logic [4:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] word;
        word = NOP_WORD;
        case (op)
            OP_ADD:   word = {F7_BASE, rs2, rs1, F3_ADD,  rd, OPC_RTYPE};
            OP_SUB:   word = {F7_ALT,  rs2, rs1, F3_ADD,  rd, OPC_RTYPE};
            OP_SLL:   word = {F7_BASE, rs2, rs1, F3_SLL,  rd, OPC_RTYPE};
            OP_SLT:   word = {F7_BASE, rs2, rs1, F3_SLT,  rd, OPC_RTYPE};
            OP_SLTU:  word = {F7_BASE, rs2, rs1, F3_SLTU, rd, OPC_RTYPE};
            OP_XOR:   word = {F7_BASE, rs2, rs1, F3_XOR,  rd, OPC_RTYPE};
            OP_SRL:   word = {F7_BASE, rs2, rs1, F3_SR,   rd, OPC_RTYPE};
            OP_SRA:   word = {F7_ALT,  rs2, rs1, F3_SR,   rd, OPC_RTYPE};
            OP_OR:    word = {F7_BASE, rs2, rs1, F3_OR,   rd, OPC_RTYPE};
            OP_AND:   word = {F7_BASE, rs2, rs1, F3_AND,  rd, OPC_RTYPE};
            OP_ADDI:  word = {imm[11:0], rs1, F3_ADD,  rd, OPC_ITYPE};
            OP_SLTI:  word = {imm[11:0], rs1, F3_SLT,  rd, OPC_ITYPE};
            OP_SLTIU: word = {imm[11:0], rs1, F3_SLTU, rd, OPC_ITYPE};
            OP_XORI:  word = {imm[11:0], rs1, F3_XOR,  rd, OPC_ITYPE};
            OP_ORI:   word = {imm[11:0], rs1, F3_OR,   rd, OPC_ITYPE};
            OP_ANDI:  word = {imm[11:0], rs1, F3_AND,  rd, OPC_ITYPE};
            OP_SLLI:  word = {F7_BASE, imm[4:0], rs1, F3_SLL, rd, OPC_ITYPE};
            OP_SRLI:  word = {F7_BASE, imm[4:0], rs1, F3_SR,  rd, OPC_ITYPE};
            OP_SRAI:  word = {F7_ALT,  imm[4:0], rs1, F3_SR,  rd, OPC_ITYPE};
            default:  word = NOP_WORD;
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with occupancy count; the read port shows the
//            head word combinationally and reads as zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic          full,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_wr;
    logic          w_rd;

    assign full    = (r_level == (AW+1)'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers rely on natural AW-bit wrap, hence DEPTH must be a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Encodes RV32I ALU/ALU-immediate field bundles into instruction
//            words and buffers them in a FIFO. Define INSTR_ENC_IMM_CHECK_EN
//            to range-check immediates (err_imm); otherwise they are truncated.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    output logic [31:0]   instruction_code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          err_illegal,
    output logic          err_imm
);

    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_imm_bad;
    logic [31:0] w_word;
    logic        r_err_illegal;

    assign in_ready    = !w_full;
    assign out_valid   = !w_empty;
    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign err_illegal = r_err_illegal;

`ifdef INSTR_ENC_IMM_CHECK_EN
    logic r_err_imm;

    always_comb begin
        w_imm_bad = 1'b0;
        if (op_is_alu_imm(in_op)) begin
            w_imm_bad = ($signed(in_imm) < -32'sd2048) || ($signed(in_imm) > 32'sd2047);
        end else if (op_is_shift_imm(in_op)) begin
            w_imm_bad = (in_imm > 32'd31);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_imm <= 1'b0;
        end else if (w_push && w_imm_bad) begin
            r_err_imm <= 1'b1;
        end
    end

    assign err_imm = r_err_imm;
`else
    assign w_imm_bad = 1'b0;
    assign err_imm   = 1'b0;
`endif

    assign w_word = w_imm_bad ? NOP_WORD
                              : encode_word(in_op, in_rd, in_rs1, in_rs2, in_imm);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_illegal <= 1'b0;
        end else if (w_push && !op_is_legal(in_op)) begin
            r_err_illegal <= 1'b1;
        end
    end

    sync_fifo #(
        .W     (32),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_push),
        .wr_data (w_word),
        .full    (w_full),
        .rd_en   (w_pop),
        .rd_data (instruction_code),
        .empty   (w_empty),
        .level   (level)
    );

endmodule
`default_nettype wire
